// File: rtl/digital_lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : digital_lock_pkg
//  Description : Shared types and constants for the keypad-to-lock sequencing
//                logic: controller state encoding, key-code width and the
//                "no key pressed" code.
//  Revision    : 1.0 - initial release
// ============================================================================
package digital_lock_pkg;

    // Width of a keypad / lock key code.
    localparam int KEY_W = 4;

    // Keypad code meaning "nothing pressed".
    localparam logic [KEY_W-1:0] NO_KEY = 4'h0;

    // Controller state encoding.
    typedef enum logic [1:0] {
        PASS        = 2'd0,
        WAIT_RESULT = 2'd1,
        LOCKOUT     = 2'd2
    } ctrl_state_e;

endpackage : digital_lock_pkg
`default_nettype wire

// File: rtl/key_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : key_edge_detect
//  Description : Turns a held keypad code into a single-cycle press strobe.
//                A press is a nonzero code whose previous-cycle sample was
//                NO_KEY, so a key held across any number of cycles (and any
//                controller state change) is reported only once.
//  Ports       : clock     - system clock, rising edge
//                reset     - synchronous, active-high
//                key_raw   - keypad code, NO_KEY when idle
//                press     - high in the cycle a new press is seen
//                key_code  - code belonging to the press strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module key_edge_detect
    import digital_lock_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [KEY_W-1:0] key_raw,
    output logic             press,
    output logic [KEY_W-1:0] key_code
);

    logic [KEY_W-1:0] key_prev_q;
    logic [KEY_W-1:0] key_prev_d;

    // The history register follows the keypad unconditionally.
    always_comb begin
        key_prev_d = key_raw;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_prev_q <= NO_KEY;
        end else begin
            key_prev_q <= key_prev_d;
        end
    end

    assign press    = (key_raw != NO_KEY) && (key_prev_q == NO_KEY);
    assign key_code = key_raw;

endmodule : key_edge_detect
`default_nettype wire

// File: rtl/lock_attempt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : lock_attempt_controller
//  Description : Sole driver of the lock's key input. Forwards each keypad
//                press as a one-cycle key pulse, counts digits while the lock
//                is locked, classifies each complete entry by watching the
//                lock's locked output, and after MAX_ATTEMPTS consecutive
//                failures blocks all key traffic for LOCKOUT_CYCLES.
//  Build option: LOCKOUT_EN - when defined, the LOCKOUT state and its timer are
//                built; when undefined, lockout is tied low and failures only
//                pulse fail_pulse and saturate the failure count.
//  Ports       : clock, reset        - clock / synchronous active-high reset
//                key_raw             - keypad code (0 = no key)
//                locked              - locked output of the lock
//                key_out             - key code to the lock, one-cycle pulses
//                fail_pulse          - one-cycle pulse per failed entry
//                lockout             - high throughout lockout
//                attempts_remaining  - MAX_ATTEMPTS - failure count
//  Revision    : 1.0 - initial release
// ============================================================================
module lock_attempt_controller
    import digital_lock_pkg::*;
#(
    parameter int PASSCODE_LENGTH = 4,
    parameter int MAX_ATTEMPTS    = 3,
    parameter int LOCKOUT_CYCLES  = 1000,
    parameter int RESULT_WAIT     = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [KEY_W-1:0]                  key_raw,
    input  logic                              locked,
    output logic [KEY_W-1:0]                  key_out,
    output logic                              fail_pulse,
    output logic                              lockout,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts_remaining
);

    localparam int DW = $clog2(PASSCODE_LENGTH + 1);
    localparam int WW = $clog2(RESULT_WAIT);
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);

    localparam logic [DW-1:0] c_digit_last = DW'(PASSCODE_LENGTH - 1);
    localparam logic [WW-1:0] c_wait_last  = WW'(RESULT_WAIT - 1);
    localparam logic [AW-1:0] c_max_fail   = AW'(MAX_ATTEMPTS);

    if (PASSCODE_LENGTH < 1 || MAX_ATTEMPTS < 1 || LOCKOUT_CYCLES < 1 ||
        RESULT_WAIT < 5) begin : g_param_check
        $error("lock_attempt_controller: illegal parameter set");
    end

    ctrl_state_e      state_q, state_d;
    logic [DW-1:0]    digit_count_q, digit_count_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [AW-1:0]    fail_count_q, fail_count_d;
    logic [AW-1:0]    fail_next;
    logic [KEY_W-1:0] key_out_q, key_out_d;
    logic             fail_pulse_q, fail_pulse_d;
    logic [AW-1:0]    attempts_q, attempts_d;

`ifdef LOCKOUT_EN
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [TW-1:0] c_timer_load = TW'(LOCKOUT_CYCLES - 1);

    logic [TW-1:0]    timer_q, timer_d;
    logic             lockout_q, lockout_d;
`endif

    logic             press;
    logic [KEY_W-1:0] key_code;

    key_edge_detect u_key_edge (
        .clock    (clock),
        .reset    (reset),
        .key_raw  (key_raw),
        .press    (press),
        .key_code (key_code)
    );

    // Failure count never wraps past MAX_ATTEMPTS.
    assign fail_next = (fail_count_q == c_max_fail) ? c_max_fail
                                                    : fail_count_q + AW'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= PASS;
            digit_count_q <= '0;
            wait_cnt_q    <= '0;
            fail_count_q  <= '0;
            key_out_q     <= NO_KEY;
            fail_pulse_q  <= 1'b0;
            attempts_q    <= c_max_fail;
`ifdef LOCKOUT_EN
            timer_q       <= '0;
            lockout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            digit_count_q <= digit_count_d;
            wait_cnt_q    <= wait_cnt_d;
            fail_count_q  <= fail_count_d;
            key_out_q     <= key_out_d;
            fail_pulse_q  <= fail_pulse_d;
            attempts_q    <= attempts_d;
`ifdef LOCKOUT_EN
            timer_q       <= timer_d;
            lockout_q     <= lockout_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        digit_count_d = digit_count_q;
        wait_cnt_d    = wait_cnt_q;
        fail_count_d  = fail_count_q;
`ifdef LOCKOUT_EN
        timer_d       = timer_q;
`endif
        case (state_q)
            PASS: begin
                // An open lock restarts digit counting from scratch.
                if (!locked) begin
                    digit_count_d = '0;
                end else if (press) begin
                    if (digit_count_q == c_digit_last) begin
                        digit_count_d = '0;
                        wait_cnt_d    = '0;
                        state_d       = WAIT_RESULT;
                    end else begin
                        digit_count_d = digit_count_q + DW'(1);
                    end
                end
            end
            WAIT_RESULT: begin
                // Success is tested first so it wins on the final wait cycle.
                if (!locked) begin
                    fail_count_d = '0;
                    state_d      = PASS;
                end else if (wait_cnt_q == c_wait_last) begin
                    fail_count_d = fail_next;
                    state_d      = PASS;
`ifdef LOCKOUT_EN
                    if (fail_next == c_max_fail) begin
                        timer_d = c_timer_load;
                        state_d = LOCKOUT;
                    end
`endif
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
`ifdef LOCKOUT_EN
            LOCKOUT: begin
                if (timer_q == '0) begin
                    fail_count_d = '0;
                    state_d      = PASS;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
`endif
            default: begin
                state_d = PASS;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (all outputs leave the block from flops)
    // ------------------------------------------------------------------
    always_comb begin
        key_out_d    = (state_q == PASS && press) ? key_code : NO_KEY;
        fail_pulse_d = (state_q == WAIT_RESULT) && locked &&
                       (wait_cnt_q == c_wait_last);
        attempts_d   = c_max_fail - fail_count_d;
`ifdef LOCKOUT_EN
        lockout_d    = (state_d == LOCKOUT);
`endif
    end

    assign key_out            = key_out_q;
    assign fail_pulse         = fail_pulse_q;
    assign attempts_remaining = attempts_q;
`ifdef LOCKOUT_EN
    assign lockout            = lockout_q;
`else
    assign lockout            = 1'b0;
`endif

endmodule : lock_attempt_controller
`default_nettype wire

// File: tb/tb_lock_attempt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lock_attempt_controller
//  Description : Scoreboard bench for lock_attempt_controller. The driver
//                emulates a keypad and a simple lock (passcode 8,1,4,8) fed
//                from the controller's key_out, predicts every output with a
//                deadline-based model and queues the predictions; a separate
//                monitor compares them against the DUT each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_attempt_controller;

    localparam int PL = 4;
    localparam int MA = 3;
    localparam int LC = 20;
    localparam int RW = 8;
    localparam int AW = $clog2(MA + 1);
`ifdef LOCKOUT_EN
    localparam bit LK_EN = 1'b1;
`else
    localparam bit LK_EN = 1'b0;
`endif

    typedef struct { int tag; logic [3:0] code; } key_ev_t;
    typedef struct { int tag; bit lo; int att; } stat_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    key_raw = 4'h0;
    logic          locked = 1'b1;
    logic [3:0]    key_out;
    logic          fail_pulse;
    logic          lockout;
    logic [AW-1:0] attempts_remaining;

    lock_attempt_controller #(
        .PASSCODE_LENGTH (PL),
        .MAX_ATTEMPTS    (MA),
        .LOCKOUT_CYCLES  (LC),
        .RESULT_WAIT     (RW)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .key_raw            (key_raw),
        .locked             (locked),
        .key_out            (key_out),
        .fail_pulse         (fail_pulse),
        .lockout            (lockout),
        .attempts_remaining (attempts_remaining)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    key_ev_t kq[$];
    int      fq[$];
    stat_t   sq[$];
    int      n_checks = 0;
    int      n_fail = 0;
    bit      done = 1'b0;

    // Lock emulation
    logic [3:0] pass_code [4] = '{4'd8, 4'd1, 4'd4, 4'd8};
    logic [3:0] lk_buf[$];
    bit         lk_open = 1'b0;
    int         lk_pending = -1;
    int         lk_delay = 3;

    // Reference model: time-stamped deadlines instead of counters.
    logic [3:0] m_prev = 4'h0;
    int         m_digits = 0;
    int         m_fails = 0;
    bit         m_await = 1'b0;
    bit         m_lo = 1'b0;
    int         m_fail_edge = 0;
    int         m_lo_exit = 0;

    task automatic model_edge(input int m, input logic [3:0] k,
                              input logic lk, input logic r);
        bit         pr;
        logic [3:0] exp_key;
        bit         exp_fail;
        exp_key  = 4'h0;
        exp_fail = 1'b0;
        if (r) begin
            m_prev = 4'h0; m_digits = 0; m_fails = 0; m_await = 0; m_lo = 0;
        end else begin
            pr     = (k != 4'h0) && (m_prev == 4'h0);
            m_prev = k;
            if (m_lo) begin
                if (m >= m_lo_exit) begin
                    m_lo = 0; m_fails = 0;
                end
            end else if (m_await) begin
                if (!lk) begin
                    m_await = 0; m_fails = 0;
                end else if (m == m_fail_edge) begin
                    m_await  = 0;
                    exp_fail = 1'b1;
                    if (m_fails < MA) m_fails++;
                    if (LK_EN && m_fails == MA) begin
                        m_lo      = 1'b1;
                        m_lo_exit = m + LC;
                    end
                end
            end else begin
                if (pr) exp_key = k;
                if (!lk) begin
                    m_digits = 0;
                end else if (pr) begin
                    m_digits++;
                    if (m_digits == PL) begin
                        m_digits    = 0;
                        m_await     = 1'b1;
                        m_fail_edge = m + RW;
                    end
                end
            end
        end
        sq.push_back('{m, m_lo, MA - m_fails});
        if (exp_key != 4'h0) kq.push_back('{m, exp_key});
        if (exp_fail) fq.push_back(m);
    endtask

    // One clock of stimulus: update the lock, drive inputs, predict outputs.
    task automatic step(input logic [3:0] k, input logic r);
        int m;
        bit ok;
        @(negedge clock);
        m = cyc + 1;
        if (r) begin
            lk_open = 1'b0; lk_pending = -1; lk_buf.delete();
        end else begin
            if (!lk_open && lk_pending >= 0 && m >= lk_pending) begin
                lk_open = 1'b1; lk_pending = -1;
            end
            if (!lk_open && lk_pending < 0 && key_out != 4'h0) begin
                lk_buf.push_back(key_out);
                if (lk_buf.size() == PL) begin
                    ok = 1'b1;
                    for (int i = 0; i < PL; i++)
                        if (lk_buf[i] != pass_code[i]) ok = 1'b0;
                    if (ok) lk_pending = m + lk_delay;
                    lk_buf.delete();
                end
            end
        end
        key_raw = k;
        reset   = r;
        locked  = !lk_open;
        model_edge(m, k, locked, r);
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'h0, 1'b0);
    endtask

    task automatic relock();
        lk_open = 1'b0; lk_pending = -1; lk_buf.delete();
    endtask

    // hold <= 0 or gap < 0 selects a random value per digit.
    task automatic enter(input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] d3,
                         input int hold, input int gap);
        logic [3:0] ds [4];
        int h;
        int g;
        ds = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            if (hold > 0) h = hold; else h = int'($urandom_range(1, 4));
            if (gap >= 0) g = gap;  else g = int'($urandom_range(0, 3));
            repeat (h) step(ds[i], 1'b0);
            repeat (g) step(4'h0, 1'b0);
        end
    endtask

    function automatic logic [3:0] rdig();
        return 4'($urandom_range(1, 15));
    endfunction

    // Driver
    initial begin
        step(4'h0, 1'b1);
        step(4'h0, 1'b1);
        idle(2);
        // correct code, lock opens
        lk_delay = 3;
        enter(4'd8, 4'd1, 4'd4, 4'd8, 3, 2);
        idle(12);
        relock();
        idle(2);
        // wrong code
        enter(4'd1, 4'd2, 4'd3, 4'd4, 3, 2);
        idle(12);
        // two more wrong entries, then presses while blocked
        enter(4'd1, 4'd2, 4'd3, 4'd4, 2, 1);
        idle(12);
        enter(4'd5, 4'd6, 4'd7, 4'd9, 2, 1);
        idle(4);
        repeat (4) begin
            step(4'd3, 1'b0); step(4'd3, 1'b0); step(4'h0, 1'b0);
        end
        idle(20);
        // key held from inside lockout through its expiry
        repeat (2) begin enter(4'd2, 4'd2, 4'd3, 4'd3, 1, 1); idle(12); end
        enter(4'd9, 4'd9, 4'd9, 4'd9, 1, 1);
        idle(10);
        repeat (30) step(4'd7, 1'b0);
        idle(2);
        step(4'd7, 1'b0); step(4'd7, 1'b0);
        idle(3);
        // reset in the middle of lockout
        repeat (3) begin enter(4'd4, 4'd4, 4'd4, 4'd4, 1, 1); idle(12); end
        idle(5);
        step(4'h0, 1'b1);
        step(4'd8, 1'b0); step(4'd8, 1'b0);
        idle(3);
        // success on the very last wait cycle
        lk_delay = RW - 1;
        enter(4'd8, 4'd1, 4'd4, 4'd8, 1, 1);
        idle(12);
        relock();
        idle(2);
        // randomized traffic
        for (int e = 0; e < 150; e++) begin
            if ($urandom_range(0, 39) == 0) step(4'h0, 1'b1);
            lk_delay = int'($urandom_range(1, 8));
            if ($urandom_range(0, 1) == 1)
                enter(4'd8, 4'd1, 4'd4, 4'd8, 0, -1);
            else
                enter(rdig(), rdig(), rdig(), rdig(), 0, -1);
            idle(int'($urandom_range(0, 12)));
            if (lk_open && $urandom_range(0, 3) != 0) relock();
        end
        idle(30);
        @(negedge clock);
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        stat_t   s;
        key_ev_t ke;
        int      ft;
        while (!done) begin
            @(posedge clock);
            #1;
            if (sq.size() > 0 && sq[0].tag == cyc) begin
                s = sq.pop_front();
                n_checks++;
                if (lockout !== s.lo) begin
                    n_fail++;
                    $display("FAIL lockout cycle %0d: got %b want %b", cyc, lockout, s.lo);
                end
                n_checks++;
                if (attempts_remaining !== AW'(s.att)) begin
                    n_fail++;
                    $display("FAIL attempts_remaining cycle %0d: got %0d want %0d",
                             cyc, attempts_remaining, s.att);
                end
            end
            while (kq.size() > 0 && kq[0].tag < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL key_out missing cycle %0d: got 0 want %0h", kq[0].tag, kq[0].code);
                void'(kq.pop_front());
            end
            if (key_out !== 4'h0) begin
                n_checks++;
                if (kq.size() > 0 && kq[0].tag == cyc) begin
                    ke = kq.pop_front();
                    if (key_out !== ke.code) begin
                        n_fail++;
                        $display("FAIL key_out cycle %0d: got %0h want %0h", cyc, key_out, ke.code);
                    end
                end else begin
                    n_fail++;
                    $display("FAIL key_out unexpected cycle %0d: got %0h want 0", cyc, key_out);
                end
            end
            while (fq.size() > 0 && fq[0] < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL fail_pulse missing cycle %0d: got 0 want 1", fq[0]);
                void'(fq.pop_front());
            end
            if (fail_pulse !== 1'b0) begin
                n_checks++;
                if (fq.size() > 0 && fq[0] == cyc) begin
                    ft = fq.pop_front();
                    if (fail_pulse !== 1'b1) begin
                        n_fail++;
                        $display("FAIL fail_pulse cycle %0d: got %b want 1", ft, fail_pulse);
                    end
                end else begin
                    n_fail++;
                    $display("FAIL fail_pulse unexpected cycle %0d: got %b want 0", cyc, fail_pulse);
                end
            end
        end
        n_checks++;
        if (kq.size() != 0) begin
            n_fail++;
            $display("FAIL key_out drain: got %0d pending want 0", kq.size());
        end
        n_checks++;
        if (fq.size() != 0) begin
            n_fail++;
            $display("FAIL fail_pulse drain: got %0d pending want 0", fq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #600000;
        $display("FAIL watchdog: got no end of stimulus want finish before 60000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_lock_attempt_controller
`default_nettype wire
